// File: rtl/rv32i_types.sv
// Shared RV32I types: multiply op encoding plus the multiply issue controller's
// state type and default watchdog limit.
package rv32i_types;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_ops;

  typedef enum logic [2:0] {
    MC_IDLE  = 3'd0,
    MC_ISSUE = 3'd1,
    MC_WAIT  = 3'd2,
    MC_RESP  = 3'd3,
    MC_DRAIN = 3'd4
  } mul_ctrl_state_t;

  localparam int MUL_WDOG_DEFAULT = 64;

endpackage

// File: rtl/mul_result_cache.sv
// One-entry multiply result cache: tag {rs1, rs2, op} plus 32-bit product.
// Lookup is combinational against the live EX operands; the entry is cleared only by rst.
module mul_result_cache
  import rv32i_types::*;
#(
  parameter bit ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en_i,
  input  logic [31:0] wr_rs1_i,
  input  logic [31:0] wr_rs2_i,
  input  mul_ops      wr_op_i,
  input  logic [31:0] wr_data_i,
  input  logic [31:0] lk_rs1_i,
  input  logic [31:0] lk_rs2_i,
  input  mul_ops      lk_op_i,
  output logic        hit_o,
  output logic [31:0] rd_data_o
);

  logic        valid_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  mul_ops      op_q;
  logic [31:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      op_q    <= MUL;
      data_q  <= '0;
    end else if (wr_en_i) begin
      valid_q <= 1'b1;
      rs1_q   <= wr_rs1_i;
      rs2_q   <= wr_rs2_i;
      op_q    <= wr_op_i;
      data_q  <= wr_data_i;
    end
  end

  assign hit_o     = ENABLE && valid_q && (rs1_q == lk_rs1_i) &&
                     (rs2_q == lk_rs2_i) && (op_q == lk_op_i);
  assign rd_data_o = data_q;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Sequencer between EX and the multi-cycle multiplier: latches operands, pulses start,
// stalls EX until the product returns, drops flushed results and serves repeats from a cache.
module mul_issue_ctrl
  import rv32i_types::*;
#(
  parameter bit CACHE_EN    = 1'b1,
  parameter int TIMEOUT_CYC = MUL_WDOG_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  mul_ops          ex_mulop,
  input  logic [31:0]     ex_rs1,
  input  logic [31:0]     ex_rs2,
  input  logic            flush,
  input  logic            mem_stall,
  output logic            ex_stall,
  output logic            result_valid,
  output logic [31:0]     result,
  output logic            mul_start,
  output logic [31:0]     mul_a,
  output logic [31:0]     mul_b,
  output mul_ops          mul_op,
  output logic            mul_load_bubble,
  output logic            mul_pipe_stalled,
  input  logic            mul_ready,
  input  logic            mul_done,
  input  logic [31:0]     mul_f,
  output logic            wdog_err,
  output mul_ctrl_state_t dbg_state
);

  localparam int          CW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO_C = CW'(TIMEOUT_CYC);

  mul_ctrl_state_t state_q, state_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  mul_ops          op_q, op_d;
  logic [31:0]     res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            cache_wr;
  logic            cache_hit;
  logic [31:0]     cache_data;
  logic            waiting;

  mul_result_cache #(
    .ENABLE(CACHE_EN)
  ) u_cache (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (cache_wr),
    .wr_rs1_i (a_q),
    .wr_rs2_i (b_q),
    .wr_op_i  (op_q),
    .wr_data_i(mul_f),
    .lk_rs1_i (ex_rs1),
    .lk_rs2_i (ex_rs2),
    .lk_op_i  (ex_mulop),
    .hit_o    (cache_hit),
    .rd_data_o(cache_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MC_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= MUL;
      res_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    a_d             = a_q;
    b_d             = b_q;
    op_d            = op_q;
    res_d           = res_q;
    cache_wr        = 1'b0;
    result_valid    = 1'b0;
    mul_start       = 1'b0;
    mul_load_bubble = 1'b1;
    unique case (state_q)
      MC_IDLE: begin
        if (ex_valid && !flush) begin
          if (cache_hit) begin
            res_d   = cache_data;
            state_d = MC_RESP;
          end else begin
            a_d     = ex_rs1;
            b_d     = ex_rs2;
            op_d    = ex_mulop;
            state_d = MC_ISSUE;
          end
        end
      end
      MC_ISSUE: begin
        // A flush here must not let the multiplier see a start it cannot complete.
        mul_load_bubble = 1'b0;
        mul_start       = !flush;
        if (flush)          state_d = MC_IDLE;
        else if (mul_ready) state_d = MC_WAIT;
      end
      MC_WAIT: begin
        if (flush) begin
          // A product arriving with the flush is already consumed; nothing left to drain.
          state_d = mul_done ? MC_IDLE : MC_DRAIN;
        end else if (mul_done) begin
          res_d    = mul_f;
          cache_wr = 1'b1;
          state_d  = MC_RESP;
        end
      end
      MC_RESP: begin
        result_valid = 1'b1;
        if (flush || !mem_stall) state_d = MC_IDLE;
      end
      MC_DRAIN: begin
        if (mul_done) state_d = MC_IDLE;
      end
      default: state_d = MC_IDLE;
    endcase
  end

  // Watchdog counts consecutive cycles spent waiting on the multiplier; the error is sticky.
  always_comb begin
    waiting = (state_q == MC_WAIT) || (state_q == MC_DRAIN);
    cnt_d   = '0;
    if (waiting) cnt_d = (cnt_q == TMO_C) ? cnt_q : cnt_q + CW'(1);
    err_d   = err_q || (cnt_d == TMO_C);
  end

  assign ex_stall         = ex_valid && (state_q != MC_RESP);
  assign result           = res_q;
  assign mul_a            = a_q;
  assign mul_b            = b_q;
  assign mul_op           = op_q;
  assign mul_pipe_stalled = 1'b0;
  assign wdog_err         = err_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, randomized traffic, and a cache-disabled instance.
module tb_mul_issue_ctrl;
  import rv32i_types::*;

  localparam int TMO = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            ex_valid, flush, mem_stall, mul_ready, mul_done;
  mul_ops          ex_mulop;
  logic [31:0]     ex_rs1, ex_rs2, mul_f;
  logic            ex_stall, result_valid, mul_start, mul_load_bubble, mul_pipe_stalled, wdog_err;
  logic [31:0]     result, mul_a, mul_b;
  mul_ops          mul_op;
  mul_ctrl_state_t dbg_state;

  mul_issue_ctrl #(.CACHE_EN(1'b1), .TIMEOUT_CYC(TMO)) u_dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mulop(ex_mulop), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .flush(flush), .mem_stall(mem_stall), .ex_stall(ex_stall),
    .result_valid(result_valid), .result(result), .mul_start(mul_start), .mul_a(mul_a),
    .mul_b(mul_b), .mul_op(mul_op), .mul_load_bubble(mul_load_bubble),
    .mul_pipe_stalled(mul_pipe_stalled), .mul_ready(mul_ready), .mul_done(mul_done),
    .mul_f(mul_f), .wdog_err(wdog_err), .dbg_state(dbg_state)
  );

  logic            n_ex_valid, n_done;
  logic [31:0]     n_f;
  logic            n_ex_stall, n_result_valid, n_mul_start, n_bubble, n_pipe_stalled, n_wdog;
  logic [31:0]     n_result, n_mul_a, n_mul_b;
  mul_ops          n_mul_op;
  mul_ctrl_state_t n_state;

  mul_issue_ctrl #(.CACHE_EN(1'b0), .TIMEOUT_CYC(TMO)) u_dut_nc (
    .clk(clk), .rst(rst), .ex_valid(n_ex_valid), .ex_mulop(MUL), .ex_rs1(32'h0001_0000),
    .ex_rs2(32'h0001_0000), .flush(1'b0), .mem_stall(1'b0), .ex_stall(n_ex_stall),
    .result_valid(n_result_valid), .result(n_result), .mul_start(n_mul_start), .mul_a(n_mul_a),
    .mul_b(n_mul_b), .mul_op(n_mul_op), .mul_load_bubble(n_bubble),
    .mul_pipe_stalled(n_pipe_stalled), .mul_ready(1'b1), .mul_done(n_done),
    .mul_f(n_f), .wdog_err(n_wdog), .dbg_state(n_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  // Reference model: what the controller owes, in transaction terms.
  bit          m_issue, m_fly, m_drain, m_resp, m_wdog;
  int          m_wcnt;
  logic [31:0] m_a, m_b, m_res;
  mul_ops      m_op;
  bit          c_v;
  logic [31:0] c_a, c_b, c_d;
  mul_ops      c_op;
  bit          chk_resp, m_consumed;

  // Behavioural multiplier on the DUT's multiplier port.
  bit          mb, hold_done, rnd_ready;
  int          mcnt, lat;
  logic [31:0] mres;
  int          n_start;

  bit          s_start;
  logic [31:0] s_a, s_b;
  mul_ops      s_op;

  function automatic logic [31:0] ref_mul(mul_ops op, logic [31:0] a, logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == MULH || op == MULHSU) ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (op == MULH) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (op == MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check();
    cmp("result_valid", 32'(result_valid), 32'(m_resp));
    cmp("ex_stall", 32'(ex_stall), 32'(ex_valid && !m_resp));
    cmp("mul_start", 32'(mul_start), 32'(m_issue && !flush));
    cmp("load_bubble", 32'(mul_load_bubble), 32'(!m_issue));
    cmp("pipe_stalled", 32'(mul_pipe_stalled), 32'd0);
    cmp("result", result, m_res);
    cmp("mul_a", mul_a, m_a);
    cmp("mul_b", mul_b, m_b);
    cmp("mul_op", 32'(mul_op), 32'(m_op));
    cmp("wdog_err", 32'(wdog_err), 32'(m_wdog));
    if (chk_resp) begin
      chk_resp = 1'b0;
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL resp_vs_ref: response with empty expected queue, got %h", result);
      end else cmp("resp_vs_ref", result, exp_q.pop_front());
    end
    s_start = mul_start;
    s_a = mul_a; s_b = mul_b; s_op = mul_op;
    if (mul_start) n_start++;
  endtask

  task automatic model_update();
    bit waiting;
    m_consumed = 1'b0;
    if (rst) begin
      m_issue = 0; m_fly = 0; m_drain = 0; m_resp = 0; m_wdog = 0; m_wcnt = 0;
      m_a = '0; m_b = '0; m_res = '0; m_op = MUL;
      c_v = 0; chk_resp = 0;
      exp_q.delete();
      return;
    end
    waiting = m_fly || m_drain;
    m_wcnt  = waiting ? m_wcnt + 1 : 0;
    if (m_wcnt >= TMO) m_wdog = 1'b1;
    if (m_issue) begin
      if (flush) begin
        m_issue = 0;
        if (exp_q.size() > 0) exp_q.delete(0);
      end else if (mul_ready) begin
        m_issue = 0; m_fly = 1;
      end
    end else if (m_fly) begin
      if (flush) begin
        m_fly = 0; m_drain = !mul_done;
        if (exp_q.size() > 0) exp_q.delete(0);
      end else if (mul_done) begin
        m_fly = 0; m_resp = 1; m_res = mul_f; chk_resp = 1;
        c_v = 1; c_a = m_a; c_b = m_b; c_op = m_op; c_d = mul_f;
      end
    end else if (m_resp) begin
      if (flush) m_resp = 0;
      else if (!mem_stall) begin m_resp = 0; m_consumed = 1; end
    end else if (m_drain) begin
      if (mul_done) m_drain = 0;
    end else if (ex_valid && !flush) begin
      exp_q.push_back(ref_mul(ex_mulop, ex_rs1, ex_rs2));
      if (c_v && c_a == ex_rs1 && c_b == ex_rs2 && c_op == ex_mulop) begin
        m_resp = 1; m_res = c_d; chk_resp = 1;
      end else begin
        m_issue = 1; m_a = ex_rs1; m_b = ex_rs2; m_op = ex_mulop;
      end
    end
  endtask

  task automatic mul_update();
    if (rst) begin
      mb = 0; mcnt = 0;
      return;
    end
    if (mul_done) mb = 0;
    else if (mb && mcnt > 0) mcnt--;
    if (s_start && mul_ready) begin
      mb = 1; mcnt = lat - 1; mres = ref_mul(s_op, s_a, s_b);
    end
  endtask

  task automatic mul_drive();
    mul_ready = !mb && (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    mul_done  = mb && (mcnt == 0) && !hold_done;
    mul_f     = mul_done ? mres : $urandom;
  endtask

  // One clock: compare at negedge, advance model/multiplier at posedge, drive #1 after.
  task automatic step();
    @(negedge clk);
    check();
    @(posedge clk);
    model_update();
    mul_update();
    #1;
    mul_drive();
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_req(input mul_ops op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit, input string name, output int cyc);
    ex_valid = 1; ex_mulop = op; ex_rs1 = a; ex_rs2 = b; flush = 0; mem_stall = 0; cyc = 0;
    while (result_valid !== 1'b1 && cyc < 200) begin step(); cyc++; end
    if (result_valid !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: no result_valid after %0d cycles", name, cyc);
    end else cmp(name, result, lit);
  endtask

  task automatic finish_req();
    mem_stall = 0;
    step();
    ex_valid = 0;
    step();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0001_0000;
      2:       return 32'h0;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic nc_test();
    int starts, cyc;
    bit s, rv;
    starts = 0;
    for (int r = 0; r < 2; r++) begin
      n_ex_valid = 1; cyc = 0; rv = 0;
      while (!rv && cyc < 50) begin
        @(negedge clk);
        s = n_mul_start; rv = n_result_valid;
        if (s) starts++;
        @(posedge clk);
        #1;
        n_done = s; n_f = '0;
        cyc++;
      end
      if (!rv) begin
        n_cmp++; n_bad++;
        $display("FAIL nocache_timeout: request %0d got no result_valid", r);
      end
      n_ex_valid = 0;
      @(posedge clk); #1; n_done = 0;
    end
    cmp("nocache_starts", 32'(starts), 32'd2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: bench did not reach its summary");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int c, s0, k, rv_cnt;
    bit req_active;
    rst = 1; ex_valid = 0; flush = 0; mem_stall = 0; ex_mulop = MUL; ex_rs1 = 0; ex_rs2 = 0;
    n_ex_valid = 0; n_done = 0; n_f = 0;
    hold_done = 0; rnd_ready = 0; lat = 2; mb = 0; mcnt = 0; n_start = 0;
    m_op = MUL; c_op = MUL; s_op = MUL;
    mul_drive();
    repeat (3) @(posedge clk);
    #1;
    step();
    cmp("rst_bubble", 32'(mul_load_bubble), 32'd1);
    cmp("rst_result_valid", 32'(result_valid), 32'd0);
    cmp("rst_result", result, 32'd0);
    cmp("rst_wdog", 32'(wdog_err), 32'd0);
    rst = 0;
    step();

    // MUL 7*6, single start pulse
    s0 = n_start;
    do_req(MUL, 32'd7, 32'd6, 32'd42, "mul_7x6", c);
    cmp("mul_7x6_starts", 32'(n_start - s0), 32'd1);
    finish_req();

    // high-half variants on all-ones operands
    do_req(MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_ones", c);
    finish_req();
    do_req(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ones", c);
    finish_req();
    do_req(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ones", c);
    finish_req();

    // repeated identical request hits the cache
    do_req(MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, "big_first", c);
    finish_req();
    s0 = n_start;
    do_req(MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, "big_hit", c);
    cmp("hit_latency", 32'(c), 32'd1);
    cmp("hit_no_start", 32'(n_start - s0), 32'd0);
    finish_req();

    // flush while waiting on the multiplier
    lat = 6;
    ex_valid = 1; ex_mulop = MUL; ex_rs1 = 32'd3; ex_rs2 = 32'd5;
    repeat (3) step();
    flush = 1;
    step();
    flush = 0; ex_valid = 0; rv_cnt = 0;
    for (int i = 0; i < 12; i++) begin step(); rv_cnt += int'(result_valid); end
    cmp("flush_no_result", 32'(rv_cnt), 32'd0);
    lat = 2;
    s0 = n_start;
    do_req(MUL, 32'd3, 32'd5, 32'd15, "mul_3x5_refetch", c);
    cmp("refetch_is_miss", 32'(n_start - s0), 32'd1);
    finish_req();

    // downstream stall holds the response
    do_req(MUL, 32'd9, 32'd9, 32'd81, "mul_9x9", c);
    mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      cmp("stall_rv_held", 32'(result_valid), 32'd1);
      cmp("stall_result_held", result, 32'd81);
    end
    mem_stall = 0;
    step();
    ex_valid = 0;
    cmp("release_rv_drop", 32'(result_valid), 32'd0);
    step();

    // watchdog: multiplier never answers
    hold_done = 1;
    ex_valid = 1; ex_mulop = MUL; ex_rs1 = 32'd2; ex_rs2 = 32'd2;
    s0 = n_start; c = 0;
    while (n_start == s0 && c < 20) begin step(); c++; end
    k = 0;
    while (wdog_err !== 1'b1 && k < 100) begin step(); k++; end
    cmp("wdog_cycles", 32'(k), 32'd64);
    while (k < 70) begin step(); k++; end
    cmp("wdog_sticky", 32'(wdog_err), 32'd1);
    rst = 1;
    step();
    rst = 0; ex_valid = 0; hold_done = 0;
    cmp("rst_wdog_clear", 32'(wdog_err), 32'd0);
    cmp("rst_to_idle", 32'(dbg_state), 32'(MC_IDLE));
    cmp("rst_bubble2", 32'(mul_load_bubble), 32'd1);
    step();

    // randomized traffic
    rnd_ready = 1; req_active = 0;
    for (int cy = 0; cy < 3000; cy++) begin
      lat = $urandom_range(1, 5);
      step();
      if (req_active && (flush || m_consumed)) req_active = 0;
      if (!req_active && $urandom_range(0, 2) == 0) begin
        req_active = 1;
        if ($urandom_range(0, 2) != 0) begin
          ex_mulop = mul_ops'(2'($urandom_range(0, 3)));
          ex_rs1 = pick();
          ex_rs2 = pick();
        end
      end
      ex_valid  = req_active;
      flush     = ($urandom_range(0, 24) == 0);
      mem_stall = ($urandom_range(0, 2) == 0);
    end
    ex_valid = 0; flush = 0; mem_stall = 0;
    repeat (30) step();

    // cache disabled: identical repeat still issues
    nc_test();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
